id_pipe_stage: RTL and testbench
================================

# id_pipe_stage

Registered, parametrised RISC-V instruction-decode stage that sits between the fetch stage and the register-read/execute stage. It splits each 32-bit instruction into its fields, builds the sign-extended immediate for every base format, classifies the format, and derives operand-use and illegal-instruction flags. Results are held in one pipeline register behind a valid/ready handshake, with stall and flush support. XLEN is selectable, so the same stage serves RV32I and RV64I cores.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. It sets the immediate and PC widths and enables the RV64 `*W` opcodes.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  kills the held instruction and any instruction accepted in the same cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  the stage can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  the decoded instruction is valid.
- out_ready  in  1  the downstream stage accepts it this cycle.
- out_pc  out  XLEN  registered PC.
- out_opcode / out_funct3 / out_funct7  out  7/3/7  raw instruction fields.
- out_rs1 / out_rs2 / out_rd  out  5/5/5  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  instruction format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_rs1_used / out_rs2_used / out_rd_we  out  1  operand-use and writeback flags.
- out_illegal  out  1  the instruction is not decodable.

## Operation
- Field split follows the RISC-V spec bit positions:
  - funct7 = [31:25], rs2 = [24:20], rs1 = [19:15], funct3 = [14:12], rd = [11:7], opcode = [6:0].
  - Fields are always passed through, including for illegal instructions.
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - XLEN=64 only: 0011011 is I and 0111011 is R.
  - Everything else is ILL, as is any word with inst[1:0] != 2'b11. Under XLEN=32, the two XLEN=64-only opcodes are ILL.
- Immediates are sign-extended from inst[31] to XLEN:
  - I: [31:20].
  - S: {[31:25], [11:7]}.
  - B: {[31], [7], [30:25], [11:8], 0}.
  - U: {[31:12], 12'b0}.
  - J: {[31], [19:12], [20], [30:21], 0}.
  - R and ILL: 0.
- Operand-use and writeback flags:
  - rs1_used = 1 for formats R, I, S and B.
  - rs2_used = 1 for formats R, S and B.
  - rd_we = 1 for formats R, I, U and J, but only when rd != 0.
  - For ILL, all three flags are 0 and illegal = 1.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and has no bubble under continuous flow.
  - Accept = in_valid && in_ready. On accept, all out_* fields load from the decode of in_inst/in_pc.
  - out_valid next value: 0 if rst or flush; otherwise 1 if accept; otherwise 0 if out_ready; otherwise it holds.
  - While out_valid && !out_ready, every out_* holds stable.
- Flush:
  - flush has priority over accept and hold. out_valid = 0 on the next cycle.
  - The data registers may load or hold; their contents are don't-care while out_valid = 0.

## Timing
- Latency is 1 cycle: an instruction accepted on edge N is visible on out_* after edge N.
- Throughput is 1 instruction per cycle when out_ready = 1.
- Reset: out_valid = 0, and every out_* data output = 0 (out_fmt = 0).
- Reset mid-stall discards the held instruction. in_ready = 1 in the first cycle after reset.
- Simultaneous accept and out_ready: the old instruction leaves and the new one loads on the same edge.
- Simultaneous flush and in_valid: the instruction is dropped, but in_ready is still reported as computed. Fetch treats the instruction as consumed.
- The decode logic (field split, format, immediate, flags) is purely combinational ahead of the register. The critical path is the opcode compare feeding the immediate mux.

## Structure
- Shared package rv_decode_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM, OP_IMM_32, OP_32);
  - the fmt codes FMT_R … FMT_ILL.
- Sub-module imm_gen (parameter XLEN) takes inst and fmt and produces imm. It is reused by the branch unit.
- The top level contains the format classifier, the flag logic and the pipeline register with its handshake.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), XLEN=32 -> fmt=I, rs1=2, rd=1, imm=0xFFFFFFFF, rs1_used=1, rs2_used=0, rd_we=1, one cycle later.
- 0x00112623 (sw x1,12(x2)) -> fmt=S, rs1=2, rs2=1, imm=0x0000000C, rd_we=0; 0xFE000EE3 (beq x0,x0,-4) -> fmt=B, imm=0xFFFFFFFC.
- XLEN=64: 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000. Then 0x0000009B (addiw-class opcode) -> fmt=I; the same word with XLEN=32 -> illegal=1, fmt=ILL.
- Stall: load an instruction, then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable all 3 cycles. Release -> the next instruction appears one cycle later with no loss or duplicate.
- Flush asserted together with in_valid=1 while out_valid=1 -> out_valid=0 the next cycle. 0x00000000 in -> illegal=1, imm=0, all use flags 0.
- rst asserted mid-stream during a stall -> all outputs 0 on the next cycle, in_ready=1.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared RISC-V opcode constants and instruction format codes
package rv_decode_pkg;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for every base RISC-V format
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);
  logic [31:0] raw;
  // Assemble the 32-bit immediate; R and ILL formats yield zero
  always_comb
    raw = fmt == FMT_I ? {{20{inst[31]}}, inst[31:20]} :
          fmt == FMT_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          fmt == FMT_B ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
          fmt == FMT_U ? {inst[31:12], 12'b0} :
          fmt == FMT_J ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                         32'b0;
  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: registered RISC-V decode stage with valid/ready, stall and flush
module id_pipe_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_rd_we,
  output logic            out_illegal
);
  localparam bit RV64 = XLEN == 64;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  logic            accept;
  // Classify the format from the opcode; words not ending in 2'b11 never match
  always_comb begin
    fmt = FMT_ILL;
    case (in_inst[6:0])
      OP:                                    fmt = FMT_R;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:  fmt = FMT_I;
      STORE:                                 fmt = FMT_S;
      BRANCH:                                fmt = FMT_B;
      LUI, AUIPC:                            fmt = FMT_U;
      JAL:                                   fmt = FMT_J;
      OP_IMM_32:                             fmt = RV64 ? FMT_I : FMT_ILL;
      OP_32:                                 fmt = RV64 ? FMT_R : FMT_ILL;
      default:                               fmt = FMT_ILL;
    endcase
  end
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst(in_inst),
    .fmt (fmt),
    .imm (imm)
  );
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Pipeline register: flush beats accept, accept beats drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_imm      <= '0;
      out_fmt      <= '0;
      out_rs1_used <= 1'b0;
      out_rs2_used <= 1'b0;
      out_rd_we    <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (accept) begin
        out_pc       <= in_pc;
        out_opcode   <= in_inst[6:0];
        out_funct3   <= in_inst[14:12];
        out_funct7   <= in_inst[31:25];
        out_rs1      <= in_inst[19:15];
        out_rs2      <= in_inst[24:20];
        out_rd       <= in_inst[11:7];
        out_imm      <= imm;
        out_fmt      <= fmt;
        out_rs1_used <= fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        out_rs2_used <= fmt inside {FMT_R, FMT_S, FMT_B};
        out_rd_we    <= fmt inside {FMT_R, FMT_I, FMT_U, FMT_J} && in_inst[11:7] != 5'd0;
        out_illegal  <= fmt == FMT_ILL;
      end
    end
  end
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: scoreboard bench driving RV64 and RV32 decode stages in lockstep
module tb_id_pipe_stage;
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic        r1;
    logic        r2;
    logic        we;
    logic        ill;
    logic [63:0] imm;
  } obs_t;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        ov64, ir64, ov32, ir32;
  logic [63:0] pc64, im64;
  logic [31:0] pc32, im32;
  logic [6:0]  op64, f7_64, op32, f7_32;
  logic [2:0]  f3_64, fm64, f3_32, fm32;
  logic [4:0]  s1_64, s2_64, rd64, s1_32, s2_32, rd32;
  logic        u1_64, u2_64, we64, il64, u1_32, u2_32, we32, il32;
  obs_t        obs64, obs32;
  txn_t        q[$];
  int          tests = 0;
  int          fails = 0;
  bit          chk_rst = 1'b0;
  logic [7:0]  ops [13] = '{8'h33, 8'h13, 8'h03, 8'h67, 8'h73, 8'h0F, 8'h23,
                            8'h63, 8'h37, 8'h17, 8'h6F, 8'h1B, 8'h3B};
  always #5 clk = ~clk;
  id_pipe_stage #(.XLEN(64)) d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(op64), .out_funct3(f3_64), .out_funct7(f7_64),
    .out_rs1(s1_64), .out_rs2(s2_64), .out_rd(rd64), .out_imm(im64), .out_fmt(fm64),
    .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_rd_we(we64), .out_illegal(il64)
  );
  id_pipe_stage #(.XLEN(32)) d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(op32), .out_funct3(f3_32), .out_funct7(f7_32),
    .out_rs1(s1_32), .out_rs2(s2_32), .out_rd(rd32), .out_imm(im32), .out_fmt(fm32),
    .out_rs1_used(u1_32), .out_rs2_used(u2_32), .out_rd_we(we32), .out_illegal(il32)
  );
  assign obs64 = {pc64, op64, f3_64, f7_64, s1_64, s2_64, rd64, fm64, u1_64, u2_64, we64, il64, im64};
  assign obs32 = {32'b0, pc32, op32, f3_32, f7_32, s1_32, s2_32, rd32, fm32, u1_32, u2_32, we32, il32, 32'b0, im32};
  function automatic void chk(string n, logic [191:0] a, logic [191:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction
  // Reference decode written from the ISA tables
  function automatic obs_t model(logic [31:0] i, logic [63:0] pc, bit rv64);
    obs_t o;
    logic [63:0] imm;
    logic [2:0] f;
    case (i[6:0])
      7'h33:                         f = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 3'd1;
      7'h23:                         f = 3'd2;
      7'h63:                         f = 3'd3;
      7'h37, 7'h17:                  f = 3'd4;
      7'h6F:                         f = 3'd5;
      7'h1B:                         f = rv64 ? 3'd1 : 3'd7;
      7'h3B:                         f = rv64 ? 3'd0 : 3'd7;
      default:                       f = 3'd7;
    endcase
    case (f)
      3'd1:    imm = longint'($signed(i[31:20]));
      3'd2:    imm = longint'($signed({i[31:25], i[11:7]}));
      3'd3:    imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4:    imm = longint'($signed({i[31:12], 12'b0}));
      3'd5:    imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: imm = 64'd0;
    endcase
    o.pc  = rv64 ? pc : {32'b0, pc[31:0]};
    o.op  = i[6:0];
    o.f3  = i[14:12];
    o.f7  = i[31:25];
    o.rs1 = i[19:15];
    o.rs2 = i[24:20];
    o.rd  = i[11:7];
    o.fmt = f;
    o.r1  = f <= 3'd3;
    o.r2  = f == 3'd0 || f == 3'd2 || f == 3'd3;
    o.we  = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) && i[11:7] != 5'd0;
    o.ill = f == 3'd7;
    o.imm = rv64 ? imm : {32'b0, imm[31:0]};
    return o;
  endfunction
  // Monitor: compare held output against scoreboard head, then track this edge
  always @(negedge clk) begin
    bit ev;
    ev = q.size() > 0;
    if (chk_rst) begin
      chk("rst_zero64", obs64, '0);
      chk("rst_zero32", obs32, '0);
    end
    chk("valid64", ov64, ev);
    chk("valid32", ov32, ev);
    chk("in_ready64", ir64, !ev || out_ready);
    chk("in_ready32", ir32, !ev || out_ready);
    if (ev) begin
      chk("dec64", obs64, model(q[0].inst, q[0].pc, 1'b1));
      chk("dec32", obs32, model(q[0].inst, q[0].pc, 1'b0));
    end
    chk_rst = rst;
    if (rst || flush) q.delete();
    else begin
      if (ev && out_ready) void'(q.pop_front());
      if (in_valid && (!ev || out_ready)) q.push_back('{in_inst, in_pc});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set(logic v, logic [31:0] i, logic [63:0] pc, logic r, logic f);
    in_valid  = v;
    in_inst   = i;
    in_pc     = pc;
    out_ready = r;
    flush     = f;
  endtask
  task automatic dir(string n, logic [31:0] i, logic [2:0] f64, logic [63:0] m64, logic [2:0] f32, logic [31:0] m32);
    set(1'b1, i, 64'hFFFF_0000_0000_1000, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk({n, "_fmt64"}, fm64, f64);
    chk({n, "_imm64"}, im64, m64);
    chk({n, "_fmt32"}, fm32, f32);
    chk({n, "_imm32"}, im32, m32);
    chk({n, "_ill32"}, il32, f32 == 3'd7);
    step();
  endtask
  initial begin
    logic [31:0] r;
    set(1'b0, 32'b0, 64'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    dir("addi", 32'hFFF10093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 32'hFFFF_FFFF);
    set(1'b1, 32'hFFF10093, 64'h40, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("addi_rs1", s1_32, 5'd2);
    chk("addi_rd", rd32, 5'd1);
    chk("addi_flags", {u1_32, u2_32, we32}, 3'b101);
    dir("sw", 32'h00112623, 3'd2, 64'hC, 3'd2, 32'hC);
    dir("beq", 32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 32'hFFFF_FFFC);
    dir("lui", 32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4, 32'h8000_0000);
    dir("addiw", 32'h0000009B, 3'd1, 64'h0, 3'd7, 32'h0);
    dir("zero", 32'h00000000, 3'd7, 64'h0, 3'd7, 32'h0);
    chk("zero_flags", {u1_64, u2_64, we64, il64}, 4'b0001);
    set(1'b1, 32'h00500113, 64'h100, 1'b0, 1'b0);
    step();
    set(1'b1, 32'h00A00193, 64'h104, 1'b0, 1'b0);
    repeat (3) begin
      chk("stall_ready", ir64, 1'b0);
      chk("stall_pc", pc64, 64'h100);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("release_pc", pc64, 64'h104);
    step();
    set(1'b1, 32'h00100093, 64'h200, 1'b0, 1'b0);
    step();
    set(1'b1, 32'h00200093, 64'h204, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", ov64, 1'b0);
    set(1'b1, 32'h00300093, 64'h300, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_valid", ov64, 1'b0);
    chk("rst_ready", ir64, 1'b1);
    chk("rst_pc", pc64, 64'h0);
    repeat (3000) begin
      r = $urandom();
      set($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0 ? {r[31:7], ops[$urandom_range(0, 12)][6:0]} : $urandom(),
          {$urandom(), $urandom()}, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    set(1'b0, 32'b0, 64'b0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
